// File: rtl/sync_updown_mod_counter.sv
// Synchronous up/down modulo counter with load, terminal count and wrap pulse.
// Define SATURATE_EN to hold at the bounds instead of wrapping (wrap tied to 0).
module sync_updown_mod_counter #(
   parameter int N         = 4,
   parameter int MOD       = 2**N,
   parameter int RESET_VAL = MOD-1
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   input  logic         up_dn,
   input  logic         load,
   input  logic [N-1:0] load_val,
   output logic [N-1:0] q,
   output logic         tc,
   output logic         wrap
);

   localparam logic [N-1:0] MAXV = N'(MOD-1);
   localparam logic [N-1:0] RSTV = N'(RESET_VAL);
   localparam logic [N:0]   MODV = (N+1)'(MOD);
   localparam bit           FULL = (MOD == (1 << N));

   logic [N-1:0] r_q;
   logic         r_wrap;
   logic [N:0]   w_inc;
   logic [N:0]   w_dec;
   logic         w_at_max;
   logic         w_at_zero;
   logic         w_up_wrap;
   logic         w_dn_wrap;
   logic [N-1:0] w_q_nxt;
   logic         w_wrap_nxt;

   assign w_inc     = {1'b0, r_q} + 1'b1;
   assign w_dec     = {1'b0, r_q} - 1'b1;
   assign w_at_max  = (r_q == MAXV);
   assign w_at_zero = (r_q == '0);
   // Full-range modulus wraps by natural carry/borrow out of bit N
   assign w_up_wrap = FULL ? w_inc[N] : w_at_max;
   assign w_dn_wrap = FULL ? w_dec[N] : w_at_zero;

   always_comb begin
      w_q_nxt    = r_q;
      w_wrap_nxt = 1'b0;
      if (load) begin
         w_q_nxt = ({1'b0, load_val} < MODV) ? load_val : MAXV;
      end else if (en) begin
`ifdef SATURATE_EN
         if (up_dn) w_q_nxt = w_up_wrap ? r_q : w_inc[N-1:0];
         else       w_q_nxt = w_dn_wrap ? r_q : w_dec[N-1:0];
`else
         if (up_dn) begin
            w_q_nxt    = w_up_wrap ? '0 : w_inc[N-1:0];
            w_wrap_nxt = w_up_wrap;
         end else begin
            w_q_nxt    = w_dn_wrap ? MAXV : w_dec[N-1:0];
            w_wrap_nxt = w_dn_wrap;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_q    <= RSTV;
         r_wrap <= 1'b0;
      end else begin
         r_q    <= w_q_nxt;
         r_wrap <= w_wrap_nxt;
      end
   end

   assign q    = r_q;
   assign wrap = r_wrap;
   assign tc   = up_dn ? w_at_max : w_at_zero;

endmodule

// File: tb/tb_sync_updown_mod_counter.sv
// Directed and randomised checks of sync_updown_mod_counter at MOD=10 and MOD=16.
// Both instances share stimulus; each has its own reference model.
module tb_sync_updown_mod_counter;

`ifdef SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       clr, en, up_dn, load;
   logic [3:0] load_val;
   logic [3:0] q, q16;
   logic       tc, tc16, wrap, wrap16;
   int         n_cmp = 0;
   int         n_err = 0;

   sync_updown_mod_counter #(.N(4), .MOD(10), .RESET_VAL(9)) dut (
      .clk(clk), .clr(clr), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .q(q), .tc(tc), .wrap(wrap)
   );

   sync_updown_mod_counter #(.N(4), .MOD(16), .RESET_VAL(15)) dut16 (
      .clk(clk), .clr(clr), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .q(q16), .tc(tc16), .wrap(wrap16)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      n_cmp++;
      if (q >= 4'd10) begin
         n_err++;
         $display("FAIL q_range: got %0d want <10", q);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int mnext(input int cur, input int m, input bit ld,
                                input int lv, input bit e, input bit u,
                                output bit w);
      w = 1'b0;
      if (ld) return (lv < m) ? lv : m-1;
      if (!e) return cur;
      if (u) begin
         if (cur == m-1) begin
            w = !SAT;
            return SAT ? cur : 0;
         end
         return cur+1;
      end
      if (cur == 0) begin
         w = !SAT;
         return SAT ? 0 : m-1;
      end
      return cur-1;
   endfunction

   task automatic test_reset;
      load = 1; load_val = 4'd3; en = 0; up_dn = 0;
      tick();
      n_cmp++;
      if (q !== 4'd3) begin
         n_err++; $display("FAIL rst_preload: got %0d want 3", q);
      end
      load = 0;
      #3 clr = 0;
      #1;
      n_cmp++;
      if (q !== 4'd9) begin
         n_err++; $display("FAIL rst_q: got %0d want 9", q);
      end
      n_cmp++;
      if (wrap !== 1'b0) begin
         n_err++; $display("FAIL rst_wrap: got %b want 0", wrap);
      end
      n_cmp++;
      if (tc !== 1'b0) begin
         n_err++; $display("FAIL rst_tc_dn: got %b want 0", tc);
      end
      up_dn = 1;
      #1;
      n_cmp++;
      if (tc !== 1'b1) begin
         n_err++; $display("FAIL rst_tc_up: got %b want 1", tc);
      end
      load = 1; load_val = 4'd2;
      tick();
      n_cmp++;
      if (q !== 4'd9) begin
         n_err++; $display("FAIL rst_load_ignored: got %0d want 9", q);
      end
      load = 0;
      #2 clr = 1;
      tick();
      n_cmp++;
      if (q !== 4'd9) begin
         n_err++; $display("FAIL rst_release_hold: got %0d want 9", q);
      end
   endtask

   task automatic test_up_wrap;
      int eq[4];
      bit ew[4];
      bit et[4];
`ifdef SATURATE_EN
      eq = '{8, 9, 9, 9}; ew = '{0, 0, 0, 0}; et = '{0, 1, 1, 1};
`else
      eq = '{8, 9, 0, 1}; ew = '{0, 0, 1, 0}; et = '{0, 1, 0, 0};
`endif
      load = 1; load_val = 4'd7; en = 0;
      tick();
      n_cmp++;
      if (q !== 4'd7) begin
         n_err++; $display("FAIL up_load: got %0d want 7", q);
      end
      load = 0; en = 1; up_dn = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if (q !== 4'(eq[i])) begin
            n_err++; $display("FAIL up_q[%0d]: got %0d want %0d", i, q, eq[i]);
         end
         n_cmp++;
         if (wrap !== ew[i]) begin
            n_err++; $display("FAIL up_wrap[%0d]: got %b want %b", i, wrap, ew[i]);
         end
         n_cmp++;
         if (tc !== et[i]) begin
            n_err++; $display("FAIL up_tc[%0d]: got %b want %b", i, tc, et[i]);
         end
      end
      en = 0;
   endtask

   task automatic test_down_wrap;
      int eq[3];
      bit ew[3];
      bit et[3];
`ifdef SATURATE_EN
      eq = '{0, 0, 0}; ew = '{0, 0, 0}; et = '{1, 1, 1};
`else
      eq = '{0, 9, 8}; ew = '{0, 1, 0}; et = '{1, 0, 0};
`endif
      load = 1; load_val = 4'd1; en = 0; up_dn = 0;
      tick();
      n_cmp++;
      if (q !== 4'd1) begin
         n_err++; $display("FAIL dn_load: got %0d want 1", q);
      end
      load = 0; en = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (q !== 4'(eq[i])) begin
            n_err++; $display("FAIL dn_q[%0d]: got %0d want %0d", i, q, eq[i]);
         end
         n_cmp++;
         if (wrap !== ew[i]) begin
            n_err++; $display("FAIL dn_wrap[%0d]: got %b want %b", i, wrap, ew[i]);
         end
         n_cmp++;
         if (tc !== et[i]) begin
            n_err++; $display("FAIL dn_tc[%0d]: got %b want %b", i, tc, et[i]);
         end
      end
      en = 0;
   endtask

   task automatic test_priority;
      load = 1; load_val = 4'd13; en = 1; up_dn = 1;
      tick();
      n_cmp++;
      if (q !== 4'd9) begin
         n_err++; $display("FAIL clamp: got %0d want 9", q);
      end
      n_cmp++;
      if (wrap !== 1'b0) begin
         n_err++; $display("FAIL clamp_wrap: got %b want 0", wrap);
      end
      load_val = 4'd4;
      tick();
      n_cmp++;
      if (q !== 4'd4) begin
         n_err++; $display("FAIL load_over_en: got %0d want 4", q);
      end
      load = 0; en = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++;
         if (q !== 4'd4 || wrap !== 1'b0) begin
            n_err++; $display("FAIL hold[%0d]: got q=%0d w=%b want q=4 w=0", i, q, wrap);
         end
      end
   endtask

`ifdef SATURATE_EN
   task automatic test_saturate;
      load = 1; load_val = 4'd8; en = 0;
      tick();
      load = 0; en = 1; up_dn = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (q !== 4'd9 || wrap !== 1'b0) begin
            n_err++; $display("FAIL sat_up[%0d]: got q=%0d w=%b want q=9 w=0", i, q, wrap);
         end
      end
      up_dn = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_cmp++;
         if (wrap !== 1'b0) begin
            n_err++; $display("FAIL sat_dn_wrap[%0d]: got %b want 0", i, wrap);
         end
      end
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (q !== 4'd0) begin
            n_err++; $display("FAIL sat_dn_hold[%0d]: got %0d want 0", i, q);
         end
         tick();
      end
      en = 0;
   endtask
`endif

   task automatic test_mod16;
      load = 1; load_val = 4'd15; en = 0; up_dn = 1;
      tick();
      n_cmp++;
      if (q16 !== 4'd15) begin
         n_err++; $display("FAIL m16_load: got %0d want 15", q16);
      end
      n_cmp++;
      if (q !== 4'd9) begin
         n_err++; $display("FAIL m10_clamp15: got %0d want 9", q);
      end
      n_cmp++;
      if (tc16 !== 1'b1) begin
         n_err++; $display("FAIL m16_tc: got %b want 1", tc16);
      end
      load = 0; en = 1;
      tick();
      n_cmp++;
      if (q16 !== (SAT ? 4'd15 : 4'd0)) begin
         n_err++; $display("FAIL m16_wrap_q: got %0d want %0d", q16, SAT ? 15 : 0);
      end
      n_cmp++;
      if (wrap16 !== !SAT) begin
         n_err++; $display("FAIL m16_wrap: got %b want %b", wrap16, !SAT);
      end
      en = 0;
   endtask

   task automatic test_random;
      int m10, m16, n10, n16, lv;
      bit w10, w16, e, u, ld;
      load = 1; load_val = 4'd5; en = 0;
      tick();
      m10 = 5; m16 = 5;
      load = 0;
      for (int i = 0; i < 10000; i++) begin
         e  = ($urandom_range(0, 3) != 0);
         u  = $urandom_range(0, 1) != 0;
         ld = ($urandom_range(0, 15) == 0);
         lv = $urandom_range(0, 15);
         en = e; up_dn = u; load = ld; load_val = 4'(lv);
         #1;
         n_cmp++;
         if (tc !== (u ? (m10 == 9) : (m10 == 0)) ||
             tc16 !== (u ? (m16 == 15) : (m16 == 0))) begin
            n_err++;
            if (n_err < 30)
               $display("FAIL rnd_tc[%0d]: got %b/%b model q %0d/%0d", i, tc, tc16, m10, m16);
         end
         n10 = mnext(m10, 10, ld, lv, e, u, w10);
         n16 = mnext(m16, 16, ld, lv, e, u, w16);
         tick();
         m10 = n10; m16 = n16;
         n_cmp++;
         if (q !== 4'(m10) || wrap !== w10) begin
            n_err++;
            if (n_err < 30)
               $display("FAIL rnd_m10[%0d]: got q=%0d w=%b want q=%0d w=%b", i, q, wrap, m10, w10);
         end
         n_cmp++;
         if (q16 !== 4'(m16) || wrap16 !== w16) begin
            n_err++;
            if (n_err < 30)
               $display("FAIL rnd_m16[%0d]: got q=%0d w=%b want q=%0d w=%b", i, q16, wrap16, m16, w16);
         end
      end
      en = 0; load = 0;
   endtask

   initial begin
      clr = 0; en = 0; up_dn = 0; load = 0; load_val = '0;
      #12 clr = 1;
      #4;
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_priority();
`ifdef SATURATE_EN
      test_saturate();
`endif
      test_mod16();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
